// File: rtl/ps2_paddle_ctrl_pkg.sv
// ps2_pkg: scan-code constants, decoder state encoding and KEYS_HELD bit positions
// shared by the PS/2 paddle controller blocks.
package ps2_pkg;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   localparam int K_W     = 0;
   localparam int K_S     = 1;
   localparam int K_UP    = 2;
   localparam int K_DOWN  = 3;
   localparam int K_SPACE = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } dec_state_e;

   // Key mask for a code seen without the E0 prefix; zero for untracked bytes.
   function automatic logic [4:0] base_mask(input logic [7:0] b);
      return b == SC_W     ? 5'b00001 :
             b == SC_S     ? 5'b00010 :
             b == SC_SPACE ? 5'b10000 : 5'b00000;
   endfunction

   // Key mask for a code seen after the E0 prefix.
   function automatic logic [4:0] ext_mask(input logic [7:0] b);
      return b == SC_UP   ? 5'b00100 :
             b == SC_DOWN ? 5'b01000 : 5'b00000;
   endfunction

endpackage

// File: rtl/ps2_paddle_ctrl_if.sv
// ps2_paddle_ctrl_if: byte stream from the PS/2 receiver into the paddle controller.
interface ps2_paddle_ctrl_if;
   logic       RX_DONE;
   logic [7:0] SCAN_BYTE;
   modport master (output RX_DONE, SCAN_BYTE);
   modport slave  (input  RX_DONE, SCAN_BYTE);
endinterface

// File: rtl/ps2_paddle_ctrl_key_decoder.sv
// ps2_key_decoder: RX_DONE edge detect, scan-set-2 prefix FSM with idle timeout,
// held-key flags and a one-shot Space make pulse.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_done_i,
   input  logic [7:0] scan_byte_i,
   output logic [4:0] keys_o,
   output logic       space_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   dec_state_e  state_q;
   logic [TW-1:0] tmo_q;
   logic [4:0]  keys_q;
   logic        space_q;
   logic        rx_q;
   logic        ev;
   logic [4:0]  base;
   logic [4:0]  ext;

   assign ev      = rx_done_i & ~rx_q;
   assign base    = base_mask(scan_byte_i);
   assign ext     = ext_mask(scan_byte_i);
   assign keys_o  = keys_q;
   assign space_o = space_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         tmo_q   <= '0;
         keys_q  <= '0;
         space_q <= 1'b0;
         rx_q    <= 1'b0;
      end else begin
         rx_q    <= rx_done_i;
         space_q <= 1'b0;
         if (ev) begin
            tmo_q <= '0;
            case (state_q)
               ST_IDLE: begin
                  state_q <= scan_byte_i == SC_EXT ? ST_EXT :
                             scan_byte_i == SC_BRK ? ST_BRK : ST_IDLE;
                  keys_q  <= keys_q | base;
                  // typematic repeats arrive with the flag already set
                  space_q <= base[K_SPACE] & ~keys_q[K_SPACE];
               end
               ST_EXT: begin
                  state_q <= scan_byte_i == SC_BRK ? ST_EXT_BRK :
                             scan_byte_i == SC_EXT ? ST_EXT : ST_IDLE;
                  keys_q  <= keys_q | ext;
               end
               ST_BRK: begin
                  state_q <= ST_IDLE;
                  keys_q  <= keys_q & ~base;
               end
               default: begin
                  state_q <= ST_IDLE;
                  keys_q  <= keys_q & ~ext;
               end
            endcase
         end else if (state_q == ST_IDLE || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // a stale prefix is dropped so the next byte decodes from IDLE
            tmo_q   <= '0;
            state_q <= ST_IDLE;
         end else begin
            tmo_q <= tmo_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_paddle_ctrl.sv
// ps2_paddle_ctrl: turns PS/2 key state into two saturating paddle positions
// stepped at a fixed tick rate, plus a serve pulse.
module ps2_paddle_ctrl
   import ps2_pkg::*;
#(
   parameter int TICK_DIV       = 416667,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int POS_W          = 10,
   parameter int PADDLE_MIN     = 0,
   parameter int PADDLE_MAX     = 400,
   parameter int PADDLE_INIT    = 200,
   parameter int STEP           = 4
) (
   input  logic             CLK100MHZ,
   input  logic             RST,
   ps2_paddle_ctrl_if.slave rx,
   output logic [POS_W-1:0] P1_POS,
   output logic [POS_W-1:0] P2_POS,
   output logic [4:0]       KEYS_HELD,
   output logic             space_Pressed
);

   localparam int CW = $clog2(TICK_DIV + 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [POS_W-1:0] p1_q, p1_d, p2_q, p2_d;
   logic             tick;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_dec (
      .clk_i      (CLK100MHZ),
      .rst_ni     (RST),
      .rx_done_i  (rx.RX_DONE),
      .scan_byte_i(rx.SCAN_BYTE),
      .keys_o     (KEYS_HELD),
      .space_o    (space_Pressed)
   );

   // One extra bit keeps the intermediate from wrapping past either rail.
   function automatic logic [POS_W-1:0] move(input logic [POS_W-1:0] pos,
                                             input logic up, input logic dn);
      logic [POS_W:0] dec;
      logic [POS_W:0] inc;
      dec = {1'b0, pos} - (POS_W+1)'(STEP);
      inc = {1'b0, pos} + (POS_W+1)'(STEP);
      if (up == dn) return pos;
      if (up) return (dec[POS_W] || dec < (POS_W+1)'(PADDLE_MIN)) ?
                     POS_W'(PADDLE_MIN) : dec[POS_W-1:0];
      return (inc > (POS_W+1)'(PADDLE_MAX)) ? POS_W'(PADDLE_MAX) : inc[POS_W-1:0];
   endfunction

   // KEYS_HELD is registered, so a tick always sees the flags from before any
   // byte arriving in the same cycle.
   always_comb begin
      tick  = cnt_q == CW'(TICK_DIV - 1);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      p1_d  = tick ? move(p1_q, KEYS_HELD[K_W], KEYS_HELD[K_S]) : p1_q;
      p2_d  = tick ? move(p2_q, KEYS_HELD[K_UP], KEYS_HELD[K_DOWN]) : p2_q;
   end

   always_ff @(posedge CLK100MHZ or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
         p1_q  <= POS_W'(PADDLE_INIT);
         p2_q  <= POS_W'(PADDLE_INIT);
      end else begin
         cnt_q <= cnt_d;
         p1_q  <= p1_d;
         p2_q  <= p2_d;
      end
   end

   assign P1_POS = p1_q;
   assign P2_POS = p2_q;

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// tb_ps2_paddle_ctrl: directed scan-code sequences with hand-computed flags and
// paddle positions; small TICK_DIV/TIMEOUT_CYCLES keep the run short.
module tb_ps2_paddle_ctrl;

   localparam int TD = 8;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] p1, p2;
   logic [4:0] keys;
   logic       sp;
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         pulses = 0;
   logic       sp_seen;

   ps2_paddle_ctrl_if bus ();

   ps2_paddle_ctrl #(.TICK_DIV(TD), .TIMEOUT_CYCLES(TO)) dut (
      .CLK100MHZ    (clk),
      .RST          (rst_n),
      .rx           (bus.slave),
      .P1_POS       (p1),
      .P2_POS       (p2),
      .KEYS_HELD    (keys),
      .space_Pressed(sp)
   );

   always #5 clk = ~clk;

   // edges since reset release; ticks land on edges where cyc % TD == 0
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;

   always @(negedge clk) if (sp) pulses <= pulses + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      bus.SCAN_BYTE = b;
      bus.RX_DONE   = 1'b1;
      @(negedge clk);
      sp_seen     = sp;
      bus.RX_DONE = 1'b0;
      @(negedge clk);
   endtask

   task automatic to_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cyc % TD != 0 && n < 2 * TD);
      if (cyc % TD != 0) begin
         vectors++;
         miscompares++;
         $error("FAIL tick_wait observed=%0d expected=0", cyc % TD);
      end
   endtask

   initial begin
      bus.RX_DONE   = 1'b0;
      bus.SCAN_BYTE = 8'h00;
      step(2);
      chk("rst_keys", keys, 0);
      chk("rst_p1", p1, 200);
      chk("rst_p2", p2, 200);
      chk("rst_sp", sp, 0);
      rst_n = 1'b1;

      // W held: P1 climbs to the top rail and sticks at 0
      to_tick();
      send(8'h1D);
      chk("w_set", keys, 5'b00001);
      to_tick();
      chk("p1_196", p1, 196);
      to_tick();
      chk("p1_192", p1, 192);
      repeat (60) to_tick();
      chk("p1_sat0", p1, 0);
      chk("p2_idle", p2, 200);
      send(8'hF0);
      send(8'h1D);
      chk("w_clr", keys, 0);

      // Down arrow: P2 descends to 400 and stops
      to_tick();
      send(8'hE0);
      send(8'h72);
      chk("down_set", keys, 5'b01000);
      to_tick();
      chk("p2_204", p2, 204);
      repeat (55) to_tick();
      chk("p2_sat400", p2, 400);
      send(8'hE0);
      send(8'hF0);
      send(8'h72);
      chk("down_clr", keys, 0);
      repeat (2) to_tick();
      chk("p2_frozen", p2, 400);

      // Space make, typematic repeats, break, make again
      send(8'h29);
      chk("sp_make1", sp_seen, 1);
      chk("sp_width", sp, 0);
      chk("sp_flag1", keys[4], 1);
      send(8'h29);
      chk("sp_rep1", sp_seen, 0);
      send(8'h29);
      chk("sp_rep2", sp_seen, 0);
      chk("sp_flag3", keys[4], 1);
      send(8'hF0);
      send(8'h29);
      chk("sp_brk", keys[4], 0);
      send(8'h29);
      chk("sp_make2", sp_seen, 1);
      chk("sp_flag5", keys[4], 1);
      step(1);
      chk("sp_pulses", pulses, 2);
      send(8'hF0);
      send(8'h29);

      // S moves P1 down; W+S together hold it
      to_tick();
      send(8'h1B);
      to_tick();
      chk("p1_4", p1, 4);
      to_tick();
      chk("p1_8", p1, 8);
      send(8'h1D);
      chk("ws_both", keys, 5'b00011);
      repeat (10) to_tick();
      chk("ws_hold", p1, 8);
      send(8'hF0);
      send(8'h1B);
      to_tick();
      chk("p1_up4", p1, 4);

      // Up make landing on the tick edge moves nothing until the next tick
      to_tick();
      send(8'hE0);
      step(5);
      send(8'h75);
      chk("up_same_tick_flag", keys, 5'b00101);
      chk("up_same_tick_pos", p2, 400);
      to_tick();
      chk("p2_396", p2, 396);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      send(8'hF0);
      send(8'h1D);
      chk("all_clr", keys, 0);

      // Prefix survives a short gap, expires after a long one
      send(8'hE0);
      step(10);
      send(8'h75);
      chk("ext_short_gap", keys, 5'b00100);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("up_clr", keys, 0);
      send(8'hE0);
      step(TO + 5);
      send(8'h75);
      chk("ext_timeout", keys, 0);
      send(8'hF0);
      step(TO + 5);
      send(8'h1D);
      chk("brk_timeout", keys, 5'b00001);

      // RX_DONE held high 5 cycles is one byte: the F0 1D break completes once
      send(8'hF0);
      bus.SCAN_BYTE = 8'h1D;
      bus.RX_DONE   = 1'b1;
      step(5);
      bus.RX_DONE = 1'b0;
      step(1);
      chk("held_once", keys, 0);

      // Async reset right after a prefix
      send(8'h1B);
      to_tick();
      send(8'hE0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_keys", keys, 0);
      chk("mid_rst_p1", p1, 200);
      chk("mid_rst_p2", p2, 200);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h75);
      chk("post_rst_keys", keys, 0);
      chk("post_rst_p1", p1, 200);
      chk("post_rst_p2", p2, 200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
